// File: rtl/alu_arbiter_if.sv
// Bus bundle between the two instruction sequencers, the arbiter and the shared ALU.
// The slave modport is the arbiter's view; the master modport is the view of everything around it.
interface alu_arbiter_if #(
   parameter int N = 32
) ();
   logic         a_req_valid;
   logic         a_req_ready;
   logic [N-1:0] a_inA;
   logic [N-1:0] a_inB;
   logic [3:0]   a_op;
   logic         a_rsp_valid;
   logic         a_rsp_ready;

   logic         b_req_valid;
   logic         b_req_ready;
   logic [N-1:0] b_inA;
   logic [N-1:0] b_inB;
   logic [3:0]   b_op;
   logic         b_rsp_valid;
   logic         b_rsp_ready;

   logic [N-1:0] rsp_out;
   logic         rsp_zero;
   logic         rsp_err;

   logic [N-1:0] alu_inA;
   logic [N-1:0] alu_inB;
   logic [3:0]   alu_op;
   logic [N-1:0] alu_out;
   logic         alu_zero;

   logic         busy;

   modport slave (
      input  a_req_valid, a_inA, a_inB, a_op, a_rsp_ready,
      output a_req_ready, a_rsp_valid,
      input  b_req_valid, b_inA, b_inB, b_op, b_rsp_ready,
      output b_req_ready, b_rsp_valid,
      output rsp_out, rsp_zero, rsp_err,
      output alu_inA, alu_inB, alu_op,
      input  alu_out, alu_zero,
      output busy
   );

   modport master (
      output a_req_valid, a_inA, a_inB, a_op, a_rsp_ready,
      input  a_req_ready, a_rsp_valid,
      output b_req_valid, b_inA, b_inB, b_op, b_rsp_ready,
      input  b_req_ready, b_rsp_valid,
      input  rsp_out, rsp_zero, rsp_err,
      input  alu_inA, alu_inB, alu_op,
      output alu_out, alu_zero,
      input  busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between requesters A and B.
// Accept (IDLE) -> drive ALU from latched operands (ISSUE) -> hold registered result (RESP).
module alu_arbiter #(
   parameter int N = 32
) (
   input  logic        clk,
   input  logic        reset,
   alu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

   state_e       state_q;
   logic         ptr_q;        // 0: A has priority, 1: B has priority
   logic         gnt_q;        // 0: A owns the transaction, 1: B owns it
   logic [N-1:0] alu_ina_q;
   logic [N-1:0] alu_inb_q;
   logic [3:0]   alu_op_q;
   logic [N-1:0] rsp_out_q;
   logic         rsp_zero_q;
   logic         rsp_err_q;
   logic         a_rsp_valid_q;
   logic         b_rsp_valid_q;

   logic         grant_a_s;
   logic         grant_b_s;
   logic         rsp_hs_s;

   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'hD: op_legal = 1'b1;
         default:                                 op_legal = 1'b0;
      endcase
   endfunction

   // Grant selection; only meaningful while idle, priority pointer breaks ties.
   always_comb begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
      if (state_q == IDLE) begin
         if (bus.a_req_valid && bus.b_req_valid) begin
            if (ptr_q == 1'b0) begin
               grant_a_s = 1'b1;
            end else begin
               grant_b_s = 1'b1;
            end
         end else if (bus.a_req_valid) begin
            grant_a_s = 1'b1;
         end else if (bus.b_req_valid) begin
            grant_b_s = 1'b1;
         end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
         end
      end else begin
         grant_a_s = 1'b0;
         grant_b_s = 1'b0;
      end
   end

   assign rsp_hs_s = (a_rsp_valid_q && bus.a_rsp_ready) ||
                     (b_rsp_valid_q && bus.b_rsp_ready);

   // Transaction FSM with all observable outputs held in registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         ptr_q         <= 1'b0;
         gnt_q         <= 1'b0;
         alu_ina_q     <= {N{1'b0}};
         alu_inb_q     <= {N{1'b0}};
         alu_op_q      <= 4'h0;
         rsp_out_q     <= {N{1'b0}};
         rsp_zero_q    <= 1'b0;
         rsp_err_q     <= 1'b0;
         a_rsp_valid_q <= 1'b0;
         b_rsp_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_b_s) begin
                  gnt_q     <= 1'b1;
                  alu_ina_q <= bus.b_inA;
                  alu_inb_q <= bus.b_inB;
                  alu_op_q  <= bus.b_op;
                  state_q   <= ISSUE;
               end else if (grant_a_s) begin
                  gnt_q     <= 1'b0;
                  alu_ina_q <= bus.a_inA;
                  alu_inb_q <= bus.a_inB;
                  alu_op_q  <= bus.a_op;
                  state_q   <= ISSUE;
               end else begin
                  state_q   <= IDLE;
               end
            end
            ISSUE: begin
               // An illegal opcode discards whatever the ALU produced.
               if (op_legal(alu_op_q)) begin
                  rsp_out_q  <= bus.alu_out;
                  rsp_zero_q <= bus.alu_zero;
                  rsp_err_q  <= 1'b0;
               end else begin
                  rsp_out_q  <= {N{1'b0}};
                  rsp_zero_q <= 1'b0;
                  rsp_err_q  <= 1'b1;
               end
               a_rsp_valid_q <= ~gnt_q;
               b_rsp_valid_q <= gnt_q;
               state_q       <= RESP;
            end
            RESP: begin
               if (rsp_hs_s) begin
                  a_rsp_valid_q <= 1'b0;
                  b_rsp_valid_q <= 1'b0;
                  ptr_q         <= ~gnt_q;
                  state_q       <= IDLE;
               end else begin
                  state_q       <= RESP;
               end
            end
            default: begin
               a_rsp_valid_q <= 1'b0;
               b_rsp_valid_q <= 1'b0;
               state_q       <= IDLE;
            end
         endcase
      end
   end

   assign bus.a_req_ready = grant_a_s;
   assign bus.b_req_ready = grant_b_s;
   assign bus.a_rsp_valid = a_rsp_valid_q;
   assign bus.b_rsp_valid = b_rsp_valid_q;
   assign bus.rsp_out     = rsp_out_q;
   assign bus.rsp_zero    = rsp_zero_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.alu_inA     = alu_ina_q;
   assign bus.alu_inB     = alu_inb_q;
   assign bus.alu_op      = alu_op_q;
   assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push expected responses,
// a negedge monitor pops and compares them at every response handshake.
module tb_alu_arbiter;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   typedef struct packed {
      logic        is_b;
      logic [31:0] out;
      logic        zero;
      logic        err;
   } exp_t;

   exp_t sb[$];

   alu_arbiter_if #(.N(32)) bus ();

   alu_arbiter #(.N(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference ALU; unknown codes return a recognisable junk value
   always_comb begin
      case (bus.alu_op)
         4'h0:    bus.alu_out = bus.alu_inA & bus.alu_inB;
         4'h1:    bus.alu_out = bus.alu_inA | bus.alu_inB;
         4'h2:    bus.alu_out = bus.alu_inA + bus.alu_inB;
         4'h6:    bus.alu_out = bus.alu_inA - bus.alu_inB;
         4'h7:    bus.alu_out = ($signed(bus.alu_inA) < $signed(bus.alu_inB)) ? 32'd1 : 32'd0;
         4'hC:    bus.alu_out = ~(bus.alu_inA | bus.alu_inB);
         4'hD:    bus.alu_out = {bus.alu_inA[15:0], bus.alu_inB[15:0]};
         default: bus.alu_out = 32'hDEADBEEF;
      endcase
   end
   assign bus.alu_zero = (bus.alu_out == 32'd0);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every response handshake consumes one scoreboard entry
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (bus.a_rsp_valid && bus.b_rsp_valid) begin
            checks++;
            failures++;
            $display("FAIL both_rsp_valid: both responses valid at cycle %0d", cyc);
         end
         if ((bus.a_rsp_valid && bus.a_rsp_ready) || (bus.b_rsp_valid && bus.b_rsp_ready)) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_rsp: response out=0x%08h with empty scoreboard (cycle %0d)",
                        bus.rsp_out, cyc);
            end else begin
               e = sb.pop_front();
               chk("rsp_owner", {31'd0, bus.b_rsp_valid}, {31'd0, e.is_b});
               chk("rsp_out",   bus.rsp_out, e.out);
               chk("rsp_zero",  {31'd0, bus.rsp_zero}, {31'd0, e.zero});
               chk("rsp_err",   {31'd0, bus.rsp_err}, {31'd0, e.err});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input bit is_b, input logic v, input logic [31:0] x,
                          input logic [31:0] y, input logic [3:0] op);
      if (is_b) begin
         bus.b_req_valid = v; bus.b_inA = x; bus.b_inB = y; bus.b_op = op;
      end else begin
         bus.a_req_valid = v; bus.a_inA = x; bus.a_inB = y; bus.a_op = op;
      end
   endtask

   // Called just after a rising edge; returns at the negedge of the grant cycle.
   task automatic wait_grant(input bit is_b, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (is_b ? bus.b_req_ready : bus.a_req_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk(is_b ? "grant_b" : "grant_a", {31'd0, ok}, 32'd1);
   endtask

   // Full single-requester transaction with latency checks.
   task automatic req(input bit is_b, input logic [31:0] x, input logic [31:0] y,
                      input logic [3:0] op, input logic [31:0] eo, input logic ez, input logic ee);
      bit ok;
      exp_t e;
      set_req(is_b, 1'b1, x, y, op);
      wait_grant(is_b, ok);
      chk("other_ready_silent", {31'd0, is_b ? bus.a_req_ready : bus.b_req_ready}, 32'd0);
      e.is_b = is_b; e.out = eo; e.zero = ez; e.err = ee;
      sb.push_back(e);
      tick();
      set_req(is_b, 1'b0, 32'd0, 32'd0, 4'h0);
      @(negedge clk);
      chk("issue_alu_op",  {28'd0, bus.alu_op}, {28'd0, op});
      chk("issue_alu_inA", bus.alu_inA, x);
      chk("issue_alu_inB", bus.alu_inB, y);
      chk("issue_no_rsp",  {30'd0, bus.a_rsp_valid, bus.b_rsp_valid}, 32'd0);
      tick();
      @(negedge clk);
      chk("t2_rsp_valid", {30'd0, bus.a_rsp_valid, bus.b_rsp_valid}, is_b ? 32'd1 : 32'd2);
      tick();
      @(negedge clk);
      chk("back_idle", {31'd0, bus.busy}, 32'd0);
      tick();
   endtask

   typedef struct {
      bit          is_b;
      logic [31:0] x;
      logic [31:0] y;
      logic [3:0]  op;
      logic [31:0] eo;
      logic        ez;
      logic        ee;
   } vec_t;

   vec_t vecs[10] = '{
      '{1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 4'h0, 32'hF000F000, 1'b0, 1'b0},
      '{1'b0, 32'd3,        32'd5,        4'h7, 32'd1,        1'b0, 1'b0},
      '{1'b1, 32'd5,        32'd3,        4'h7, 32'd0,        1'b1, 1'b0},
      '{1'b0, 32'hFFFFFFFF, 32'd1,        4'h7, 32'd1,        1'b0, 1'b0},
      '{1'b1, 32'd0,        32'd0,        4'hC, 32'hFFFFFFFF, 1'b0, 1'b0},
      '{1'b0, 32'h12345678, 32'h9ABCDEF0, 4'hD, 32'h5678DEF0, 1'b0, 1'b0},
      '{1'b0, 32'd11,       32'd22,       4'h3, 32'd0,        1'b0, 1'b1},
      '{1'b0, 32'hFFFFFFFF, 32'd1,        4'h2, 32'd0,        1'b1, 1'b0},
      '{1'b1, 32'd4,        32'd4,        4'hF, 32'd0,        1'b0, 1'b1},
      '{1'b1, 32'd10,       32'd3,        4'h6, 32'd7,        1'b0, 1'b0}
   };

   initial begin
      bit   ok;
      int   last_cyc;
      exp_t e;

      reset = 1'b1;
      bus.a_rsp_ready = 1'b1;
      bus.b_rsp_ready = 1'b1;
      set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
      set_req(1'b1, 1'b0, 32'd0, 32'd0, 4'h0);
      tick();
      tick();
      reset = 1'b0;

      // Reset then idle
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_ready", {30'd0, bus.a_req_ready, bus.b_req_ready}, 32'd0);
         chk("idle_flags", {28'd0, bus.busy, bus.a_rsp_valid, bus.b_rsp_valid, bus.rsp_err | bus.rsp_zero}, 32'd0);
         chk("idle_rsp_out", bus.rsp_out, 32'd0);
         chk("idle_alu", bus.alu_inA | bus.alu_inB | {28'd0, bus.alu_op}, 32'd0);
         tick();
      end

      // Single A ADD
      req(1'b0, 32'd5, 32'd7, 4'h2, 32'd12, 1'b0, 1'b0);

      // Round-robin with both requesters continuously valid
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_req(1'b0, 1'b1, 32'd9, 32'd9, 4'h6);
      set_req(1'b1, 1'b1, 32'h000000F0, 32'h0000000F, 4'h1);
      last_cyc = 0;
      for (int k = 0; k < 4; k++) begin
         ok = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.a_req_ready || bus.b_req_ready) begin
               ok = 1'b1;
               break;
            end
            tick();
         end
         chk("rr_grant_seen", {31'd0, ok}, 32'd1);
         chk("rr_grant_owner", {30'd0, bus.a_req_ready, bus.b_req_ready}, (k % 2 == 1) ? 32'd1 : 32'd2);
         if (k > 0) chk("rr_interval", cyc - last_cyc, 32'd3);
         last_cyc = cyc;
         e.is_b = (k % 2 == 1);
         e.out  = e.is_b ? 32'h000000FF : 32'd0;
         e.zero = !e.is_b;
         e.err  = 1'b0;
         sb.push_back(e);
         tick();
         if (k == 3) begin
            set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
            set_req(1'b1, 1'b0, 32'd0, 32'd0, 4'h0);
         end
      end
      repeat (3) tick();

      // Backpressure on B while A waits
      bus.b_rsp_ready = 1'b0;
      set_req(1'b1, 1'b1, 32'h00000100, 32'h00000023, 4'h2);
      wait_grant(1'b1, ok);
      e.is_b = 1'b1; e.out = 32'h00000123; e.zero = 1'b0; e.err = 1'b0;
      sb.push_back(e);
      tick();
      set_req(1'b1, 1'b0, 32'd0, 32'd0, 4'h0);
      set_req(1'b0, 1'b1, 32'hFF00FF00, 32'h0F0F0F0F, 4'h0);
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_b_valid", {31'd0, bus.b_rsp_valid}, 32'd1);
         chk("bp_rsp_out", bus.rsp_out, 32'h00000123);
         chk("bp_a_ready", {31'd0, bus.a_req_ready}, 32'd0);
         tick();
      end
      bus.b_rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_hs_a_ready", {31'd0, bus.a_req_ready}, 32'd0);
      tick();
      @(negedge clk);
      chk("bp_a_granted_next", {31'd0, bus.a_req_ready}, 32'd1);
      e.is_b = 1'b0; e.out = 32'h0F000F00; e.zero = 1'b0; e.err = 1'b0;
      sb.push_back(e);
      tick();
      set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
      repeat (3) tick();

      // Directed op table including illegal opcodes
      foreach (vecs[i])
         req(vecs[i].is_b, vecs[i].x, vecs[i].y, vecs[i].op, vecs[i].eo, vecs[i].ez, vecs[i].ee);

      // Reset during ISSUE abandons the transaction
      set_req(1'b1, 1'b1, 32'd50, 32'd60, 4'h2);
      wait_grant(1'b1, ok);
      tick();
      set_req(1'b1, 1'b0, 32'd0, 32'd0, 4'h0);
      @(negedge clk);
      chk("mid_in_issue", {31'd0, bus.busy}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("mid_idle", {31'd0, bus.busy}, 32'd0);
      chk("mid_no_rsp", {30'd0, bus.a_rsp_valid, bus.b_rsp_valid}, 32'd0);
      chk("mid_alu_op", {28'd0, bus.alu_op}, 32'd0);
      tick();
      set_req(1'b0, 1'b1, 32'd1, 32'd1, 4'h2);
      set_req(1'b1, 1'b1, 32'd2, 32'd2, 4'h2);
      @(negedge clk);
      chk("mid_ptr_a", {30'd0, bus.a_req_ready, bus.b_req_ready}, 32'd2);
      e.is_b = 1'b0; e.out = 32'd2; e.zero = 1'b0; e.err = 1'b0;
      sb.push_back(e);
      tick();
      set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
      wait_grant(1'b1, ok);
      e.is_b = 1'b1; e.out = 32'd4; e.zero = 1'b0; e.err = 1'b0;
      sb.push_back(e);
      tick();
      set_req(1'b1, 1'b0, 32'd0, 32'd0, 4'h0);

      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      repeat (2) tick();
      chk("sb_drained", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters, A and B.
- The ALU interface is inA, inB, op[3:0] in and out, zero back; codes 0x0 AND, 0x1 OR, 0x2 ADD, 0x6 SUB, 0x7 SLT, 0xC NOR, 0xD pack.
- Arbitrates round-robin, latches operands, drives the ALU for one cycle, registers the result and returns it with a valid/ready handshake.
- Sits between the instruction sequencers and the single ALU instance.

Parameters:
- N, 32, operand/result width (ALU width).

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- a_req_valid  input  1  requester A has an operation
- a_req_ready  output  1  A's request accepted this cycle
- a_inA  input  N  A operand A
- a_inB  input  N  A operand B
- a_op  input  4  A opcode
- a_rsp_valid  output  1  result for A available
- a_rsp_ready  input  1  A consumes the result
- b_req_valid, b_req_ready, b_inA, b_inB, b_op, b_rsp_valid, b_rsp_ready  (same as A, for requester B)
- rsp_out  output  N  registered result (shared by both responses)
- rsp_zero  output  1  registered zero flag
- rsp_err  output  1  opcode was illegal
- alu_inA  output  N  to ALU inA
- alu_inB  output  N  to ALU inB
- alu_op  output  4  to ALU op
- alu_out  input  N  from ALU out
- alu_zero  input  1  from ALU zero
- busy  output  1  state != IDLE

Behaviour:
- One clock; reset is synchronous and active-high.
- On reset:
  - state=IDLE, priority pointer=A.
  - All ready/valid outputs 0; rsp_out=0, rsp_zero=0, rsp_err=0.
  - alu_inA=0, alu_inB=0, alu_op=0.
  - Reset mid-operation abandons the transaction; no response is produced.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If exactly one req_valid is high, grant it.
  - If both are high, grant the requester selected by the priority pointer.
  - On grant, assert x_req_ready combinationally for that requester only in this cycle (accept = valid&&ready).
  - Latch inA/inB/op and the grant id into registers; go to ISSUE.
  - No valid: stay in IDLE with ready=0.
- ISSUE:
  - alu_* are driven from the latched registers (registered outputs, stable the whole cycle).
  - Legal op = {0,1,2,6,7,C,D}.
  - At the clock edge: rsp_out<=alu_out, rsp_zero<=alu_zero, rsp_err<=0; go to RESP.
  - Illegal op: rsp_out<=0, rsp_zero<=0, rsp_err<=1, and the ALU result is ignored.
- RESP:
  - Assert rsp_valid for the granted requester only; rsp_out/zero/err are held stable.
  - When that requester's rsp_ready is high: go to IDLE and set the pointer to the other requester.
  - Backpressure holds RESP indefinitely; no new grant is issued.
- Latency and throughput:
  - Request accepted at cycle t gives rsp_valid at cycle t+2.
  - Minimum initiation interval is 3 cycles (accept, issue, respond with immediate ready).
  - A request arriving in RESP is not accepted until IDLE (the next cycle after the handshake).
- req_valid may drop before acceptance without effect; operands are sampled only at accept.
- alu_* retain the last issued values outside ISSUE (no toggling).
- No combinational path from alu_out to any output except through the registered rsp_out.
- Result widths follow the ALU (N bits); the arbiter performs no arithmetic.

Test Plan:
- Reset then idle:
  - Stimulus: reset=1 for 2 cycles, all valids 0.
  - Required: outputs 0, busy=0, no ready for 10 cycles.
- Single A ADD:
  - Stimulus: a_inA=5, a_inB=7, op=0x2, a_rsp_ready=1; ALU model returns the sum.
  - Required: a_req_ready at t, alu_op=2 at t+1, a_rsp_valid at t+2 with rsp_out=12, rsp_zero=0; b_* silent.
- Simultaneous requests, round-robin:
  - Stimulus: both valid continuously; A SUB 9-9, B OR 0xF0|0x0F.
  - Required: grants A, B, A, B; A gets rsp_out=0 with rsp_zero=1, B gets 0xFF.
- Backpressure:
  - Stimulus: b_rsp_ready=0 for 5 cycles while A is valid.
  - Required: b_rsp_valid and rsp_out held for 5 cycles, a_req_ready=0 throughout; A is granted the cycle after the B handshake.
- Illegal opcode:
  - Stimulus: a_op=0x3.
  - Required: rsp_err=1, rsp_out=0, rsp_zero=0 at t+2; the next legal op returns rsp_err=0.
- Reset mid-operation:
  - Stimulus: reset asserted in ISSUE.
  - Required: next cycle state IDLE, no rsp_valid, pointer=A; a fresh request completes normally.
